// File: rtl/nfu_pkg.sv
// Shared NFU constants, per-level pipeline tag type and saturation-bound helpers.
// Used by the NFU-2 accumulation tree (nfu2_acc_tree) and its adder (sat_add).
package nfu_pkg;

    localparam int N_DEF      = 16;
    localparam int Q_DEF      = 10;
    localparam int NUM_IN_DEF = 4;

    // Sideband that travels with every tree level; last is only meaningful when valid.
    typedef struct packed {
        logic valid;
        logic last;
    } stage_tag_t;

    // Largest positive n-bit two's complement value, zero-extended to 64 bits.
    function automatic logic [63:0] SAT_MAX(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

    // Most negative n-bit two's complement value; the low n bits are 100..0.
    function automatic logic [63:0] SAT_MIN(input int n);
        return ~SAT_MAX(n);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational N-bit signed adder: saturating when NFU2_SAT_EN is defined,
// wrapping modulo 2^N otherwise.
module sat_add
    import nfu_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

`ifdef NFU2_SAT_EN
    localparam logic [N-1:0] MAX_V = N'(SAT_MAX(N));
    localparam logic [N-1:0] MIN_V = N'(SAT_MIN(N));

    logic [N:0] ext;

    assign ext = {a[N-1], a} + {b[N-1], b};

    // Disagreeing top two bits of the sign-extended sum flag overflow; ext[N] is the true sign.
    // NOTE: y is assigned on every path (default arm) so no latch is inferred.
    always_comb begin
        case ({ext[N], ext[N-1]})
            2'b01:   y = MAX_V;
            2'b10:   y = MIN_V;
            default: y = ext[N-1:0];
        endcase
    end
`else
    assign y = a + b;
`endif

endmodule

// File: rtl/nfu2_acc_tree.sv
// NFU-2: registered binary adder tree over NUM_IN product lanes feeding a group accumulator.
// Build option: define NFU2_SAT_EN for saturating additions (default wraps modulo 2^N).
module nfu2_acc_tree
    import nfu_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int Q      = Q_DEF,
    parameter int NUM_IN = NUM_IN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_IN*N-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_data
);

    localparam int L = $clog2(NUM_IN);

    if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
        $error("nfu2_acc_tree: NUM_IN must be a power of two and at least 2");
    end
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("nfu2_acc_tree: Q must lie in [0, N-1]");
    end

    // The whole pipeline moves as one unit; a held output stalls every stage behind it.
    logic advance;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int LANES_IN  = NUM_IN >> k;
        localparam int LANES_OUT = LANES_IN / 2;

        logic [LANES_IN*N-1:0]  src_data;
        stage_tag_t             src_tag;
        logic [LANES_OUT*N-1:0] sum;
        logic [LANES_OUT*N-1:0] data_q;
        stage_tag_t             tag_q;

        if (k == 0) begin : g_head
            assign src_data = in_data;
            assign src_tag  = '{valid: in_valid, last: in_valid && in_last};
        end else begin : g_body
            assign src_data = g_lvl[k-1].data_q;
            assign src_tag  = g_lvl[k-1].tag_q;
        end

        for (genvar j = 0; j < LANES_OUT; j++) begin : g_add
            sat_add #(.N(N)) u_add (
                .a (src_data[(2*j)*N +: N]),
                .b (src_data[(2*j+1)*N +: N]),
                .y (sum[j*N +: N])
            );
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                tag_q <= '0;
            end else if (advance) begin
                tag_q <= src_tag;
            end
        end

        // NOTE: tree data needs no reset; the cleared tag marks it as a bubble until real data arrives.
        always_ff @(posedge clk) begin
            if (advance) begin
                data_q <= sum;
            end
        end
    end

    logic [N-1:0] tree_sum;
    stage_tag_t   tree_tag;
    logic [N-1:0] acc;
    logic [N-1:0] acc_sum;

    assign tree_sum = g_lvl[L-1].data_q;
    assign tree_tag = g_lvl[L-1].tag_q;

    sat_add #(.N(N)) u_acc_add (
        .a (acc),
        .b (tree_sum),
        .y (acc_sum)
    );

    // Advancing implies the current output (if any) is consumed, so out_valid drops unless reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (advance) begin
            out_valid <= 1'b0;
            if (tree_tag.valid) begin
                if (tree_tag.last) begin
                    out_data  <= acc_sum;
                    out_valid <= 1'b1;
                    acc       <= '0;
                end else begin
                    acc <= acc_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_nfu2_acc_tree.sv
// Self-checking bench for nfu2_acc_tree (NUM_IN=4, N=16): directed table, corner sequences,
// and randomized traffic checked by a group-sum reference model and scoreboard.
module tb_nfu2_acc_tree;

    localparam int N      = 16;
    localparam int Q      = 10;
    localparam int NUM_IN = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [NUM_IN*N-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic [N-1:0]        out_data;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] exp_q[$];
    logic [N-1:0] acc_m = '0;

    typedef struct {
        string        name;
        logic [N-1:0] lane[NUM_IN];
        logic [N-1:0] exp;
    } vec_t;

    vec_t vecs[6];

    nfu2_acc_tree #(.N(N), .Q(Q), .NUM_IN(NUM_IN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: signed 16-bit add, clamped or wrapped according to the build option.
    function automatic logic [N-1:0] add_m(input logic [N-1:0] a, input logic [N-1:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef NFU2_SAT_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return s[N-1:0];
    endfunction

    function automatic logic [N-1:0] tree_ref(input logic [NUM_IN*N-1:0] d);
        return add_m(add_m(d[15:0], d[31:16]), add_m(d[47:32], d[63:48]));
    endfunction

    function automatic logic [NUM_IN*N-1:0] pack(input logic [N-1:0] l0, input logic [N-1:0] l1,
                                                 input logic [N-1:0] l2, input logic [N-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // Scoreboard: observes both handshakes between clock edges and tracks group sums.
    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            exp_q.delete();
            acc_m = '0;
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got output 0x%0h required no output", out_data);
                end else begin
                    check("sb_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
                end
            end
            if (in_valid && in_ready) begin
                logic [N-1:0] s;
                s = add_m(acc_m, tree_ref(in_data));
                if (in_last) begin
                    exp_q.push_back(s);
                    acc_m = '0;
                end else begin
                    acc_m = s;
                end
            end
        end
    end

    // Presents a beat at a falling edge and returns once it will be accepted at the next rising edge.
    task automatic send(input logic [NUM_IN*N-1:0] d, input logic last);
        bit ok;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            #2;
            if (in_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 required 1 within 50 cycles");
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_out(input string name, input logic [N-1:0] exp);
        bit found;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: got out_valid=0 required 1 within 20 cycles", name);
        end else begin
            check(name, {16'h0, out_data}, {16'h0, exp});
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #3;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{name: "t_ones",   lane: '{16'h0400, 16'h0400, 16'h0400, 16'h0400}, exp: 16'h1000};
        vecs[1] = '{name: "t_mixed",  lane: '{16'h0400, 16'hFC00, 16'h0200, 16'h0000}, exp: 16'h0200};
`ifdef NFU2_SAT_EN
        vecs[2] = '{name: "t_ovf",    lane: '{16'h7000, 16'h7000, 16'h7000, 16'h7000}, exp: 16'h7FFF};
        vecs[3] = '{name: "t_unf",    lane: '{16'h8000, 16'h8000, 16'h8000, 16'h8000}, exp: 16'h8000};
`else
        vecs[2] = '{name: "t_ovf",    lane: '{16'h7000, 16'h7000, 16'h7000, 16'h7000}, exp: 16'hC000};
        vecs[3] = '{name: "t_unf",    lane: '{16'h8000, 16'h8000, 16'h8000, 16'h8000}, exp: 16'h0000};
`endif
        vecs[4] = '{name: "t_small",  lane: '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, exp: 16'h000A};
        vecs[5] = '{name: "t_neg",    lane: '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, exp: 16'hFFFC};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        // One-beat groups: exact latency (edge 3 after acceptance) and a single-cycle output.
        foreach (vecs[v]) begin
            send(pack(vecs[v].lane[0], vecs[v].lane[1], vecs[v].lane[2], vecs[v].lane[3]), 1'b1);
            idle();
            check({vecs[v].name, "_e1_valid"}, out_valid, 0);
            @(negedge clk);
            check({vecs[v].name, "_e2_valid"}, out_valid, 0);
            @(negedge clk);
            check({vecs[v].name, "_e3_valid"}, out_valid, 1);
            check({vecs[v].name, "_data"}, {16'h0, out_data}, {16'h0, vecs[v].exp});
            @(negedge clk);
            check({vecs[v].name, "_one_cycle"}, out_valid, 0);
        end

        // Three-beat group: 0x0200 per beat accumulates to 0x0600.
        for (int b = 0; b < 3; b++) send(pack(16'h0400, 16'hFC00, 16'h0200, 16'h0000), b == 2);
        idle();
        wait_out("grp3", 16'h0600);
        @(negedge clk);
        check("grp3_single", out_valid, 0);

        // Backpressure: output held for 5 cycles with a beat waiting at the input.
        out_ready = 1'b0;
        send(pack(16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b1);
        idle();
        wait_out("bp_first", 16'h0400);
        begin
            logic [N-1:0] held;
            held     = out_data;
            in_valid = 1'b1;
            in_data  = pack(16'h0200, 16'h0200, 16'h0200, 16'h0200);
            in_last  = 1'b1;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_out_data", {16'h0, out_data}, {16'h0, held});
            end
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        send(pack(16'h0300, 16'h0300, 16'h0300, 16'h0300), 1'b1);
        send(pack(16'h0010, 16'h0020, 16'h0030, 16'h0040), 1'b0);
        send(pack(16'h0001, 16'h0001, 16'h0001, 16'h0001), 1'b1);
        idle();
        drain("bp_drain");

        // Reset mid-group discards the partial sum and the beats still in the tree.
        send(pack(16'h0400, 16'h0400, 16'h0400, 16'h0400), 1'b0);
        send(pack(16'h0400, 16'h0400, 16'h0400, 16'h0400), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        send(pack(16'h0100, 16'h0100, 16'h0100, 16'h0100), 1'b1);
        idle();
        wait_out("mid_rst_sum", 16'h0400);
        drain("mid_rst_drain");

        // Back-to-back one-beat groups produce one output per cycle with no gaps.
        fork
            begin
                for (int k = 1; k <= 8; k++) begin
                    logic [N-1:0] lv;
                    lv = N'(k * 16'h0100);
                    send(pack(lv, lv, lv, lv), 1'b1);
                end
                idle();
            end
            begin
                bit seen;
                seen = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1;
                        break;
                    end
                end
                if (!seen) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_start: got out_valid=0 required 1 within 20 cycles");
                end else begin
                    for (int k = 1; k <= 8; k++) begin
                        check("b2b_valid", out_valid, 1);
                        check("b2b_data", {16'h0, out_data}, 32'(k * 32'h0400));
                        @(negedge clk);
                    end
                    check("b2b_end", out_valid, 0);
                end
            end
        join
        drain("b2b_drain");

        // Randomized traffic with bubbles and backpressure; a beat is held until accepted.
        begin
            bit taken;
            taken = 1;
            for (int c = 0; c < 400; c++) begin
                @(negedge clk);
                if (!in_valid || taken) begin
                    in_valid = $urandom_range(0, 3) != 0;
                    in_data  = {$urandom(), $urandom()};
                    in_last  = $urandom_range(0, 2) == 0;
                end
                out_ready = $urandom_range(0, 3) != 0;
                #2;
                taken = in_valid && in_ready;
            end
        end
        out_ready = 1'b1;
        send(pack(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b1);
        idle();
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nfu2_acc_tree.md
NFU2_ACC_TREE -- requirements
Module: nfu2_acc_tree

Interface
REQ-001 SHALL have parameter N, default 16, meaning the width of each signed fixed-point word.
REQ-002 SHALL have parameter Q, default 10, meaning the number of fractional bits; it does not affect the arithmetic.
REQ-003 SHALL have parameter NUM_IN, default 4, meaning the product lanes per beat; it must be a power of two and at least 2. L = log2(NUM_IN).
REQ-004 SHALL have port clk, input, width 1: the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst, input, width 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, width 1: a product beat is present.
REQ-007 SHALL have port in_ready, output, width 1: the block accepts a beat this cycle.
REQ-008 SHALL have port in_data, input, width NUM_IN*N: the NFU-1 multiplier products; lane i occupies bits [i*N +: N].
REQ-009 SHALL have port in_last, input, width 1: the beat closes the current accumulation group.
REQ-010 SHALL have port out_valid, output, width 1: out_data holds a finished group sum.
REQ-011 SHALL have port out_ready, input, width 1: downstream (NFU-3) accepts the output.
REQ-012 SHALL have port out_data, output, width N: the group sum, signed two's complement.

Function
REQ-013 SHALL accept a beat on a rising edge when in_valid and in_ready are both high.
REQ-014 SHALL define advance = !out_valid || out_ready and drive in_ready = advance, combinationally.
REQ-015 SHALL freeze every pipeline register (data, valid, last, accumulator) while advance is low.
REQ-016 SHALL reduce the lanes with a binary adder tree of L registered levels; each level adds adjacent pairs into N-bit results.
REQ-017 SHALL carry a valid bit and a last bit alongside each tree level; in_valid=0 cycles propagate as bubbles and never modify the accumulator.
REQ-018 SHALL, when a valid non-last tree result leaves the final level, compute acc <= acc + tree_sum.
REQ-019 SHALL, when a valid last tree result leaves the final level:
- set out_data <= acc + tree_sum;
- set out_valid <= 1;
- clear acc <= 0 on the same edge.
REQ-020 SHALL make a last beat's sum visible on out_valid after L+1 advancing edges, counting the acceptance edge as edge 1 (3 edges for NUM_IN=4).
REQ-021 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-022 SHALL clear out_valid after a handshake unless a new last result is loaded on the same edge.
REQ-023 SHALL sustain one group completion per cycle when every beat has in_last=1 and out_ready is held high.
REQ-024 SHALL treat a one-beat group (in_last on the first beat) as acc=0 plus tree_sum.

Reset
REQ-025 SHALL, while rst=1 at a rising edge:
- clear all tree valid and last bits;
- clear acc and out_data to 0;
- clear out_valid to 0;
- discard any partial group, including reset mid-group.
REQ-026 SHALL give rst priority over advance and over any incoming beat on the same edge.

Configuration
REQ-027 SHALL, with macro NFU2_SAT_EN defined, make every tree and accumulator addition saturating: overflow clamps to 0x7FFF and underflow to 0x8000 (scaled to N).
REQ-028 SHALL, without NFU2_SAT_EN, make every addition wrap modulo 2^N.

Structure
REQ-029 SHALL place the constants N_DEF=16, Q_DEF=10, NUM_IN_DEF=4 and the functions SAT_MAX/SAT_MIN(N) in the shared package nfu_pkg.
REQ-030 SHALL implement each adder as an instance of the combinational sub-module sat_add (inputs a, b; output y; parameter N), which contains the NFU2_SAT_EN switch.

Verification (NUM_IN=4, Q=10, 1.0=0x0400)
REQ-031 SHALL cover: one beat with all lanes 0x0400 and in_last=1 -> out_data=0x1000, out_valid high after 3 edges, for 1 cycle with out_ready=1.
REQ-032 SHALL cover: 3 beats, each with lanes {0x0400,0xFC00,0x0200,0x0000}, last on beat 3 -> a single output 0x0600.
REQ-033 SHALL cover: all lanes 0x7000, in_last=1 -> 0x7FFF with NFU2_SAT_EN defined; 0xC000 without it.
REQ-034 SHALL cover: out_ready=0 for 5 cycles while out_valid=1 -> in_ready=0, out_data unchanged; after release, all later groups arrive intact and in order.
REQ-035 SHALL cover: 2 non-last beats of 0x0400 lanes, then rst for 1 cycle, then one last beat of 0x0100 lanes -> out_data=0x0400.
REQ-036 SHALL cover: 8 consecutive last beats with values k*0x0100 per lane (k=1..8) and out_ready=1 -> 8 consecutive outputs k*0x0400, with no gaps.
